// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types, constants and helpers for the FIFO write arbiter and its schedulers.
package fifo_arb_pkg;
  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;
  localparam int WDOG_LIMIT = 15;
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, searching from ptr+1 with wrap.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);
  // Later hits overwrite earlier ones, so the smallest offset from ptr wins.
  always_comb begin
    onehot = '0;
    idx = '0;
    any = 1'b0;
    for (int k = N; k >= 1; k--)
      for (int i = 0; i < N; i++)
        if (req[i] && (int'(ptr) + k) % N == i) begin
          onehot = '0;
          onehot[i] = 1'b1;
          idx = IW'(i);
          any = 1'b1;
        end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-locked sharing of one async_fifo write port.
// Define FWA_WATCHDOG_EN to add a stall watchdog that drops a stuck grant and pulses wdog_err.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 4,
  parameter int MAX_BURST  = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_vld,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  input  logic [NUM_REQ-1:0]               req_last,
  output logic [NUM_REQ-1:0]               req_rdy,
  output logic                             fifo_wr_en,
  output logic [DATA_WIDTH-1:0]            fifo_wr_data,
  input  logic                             fifo_full,
  input  logic                             fifo_afull,
`ifdef FWA_WATCHDOG_EN
  output logic                             wdog_err,
`endif
  output logic                             grant_vld,
  output logic [clog2_min1(NUM_REQ)-1:0]   grant_id
);
  localparam int IW = clog2_min1(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  state_t state, state_nxt;
  logic [IW-1:0] rr_ptr, ptr_nxt, id_nxt, win_idx;
  logic [BW-1:0] beat_cnt, cnt_nxt;
  logic [NUM_REQ-1:0] unused_onehot;
  logic any, vld_g, last_g, rdy_g, acc, done, wdog_hit;
  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req(req_vld),
    .ptr(rr_ptr),
    .onehot(unused_onehot),
    .idx(win_idx),
    .any(any)
  );
  always_comb begin
    vld_g = 1'b0;
    last_g = 1'b0;
    fifo_wr_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant_id == IW'(i)) begin
        vld_g = req_vld[i];
        last_g = req_last[i];
        fifo_wr_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
  end
  // rst gates the handshake so nothing is written during a reset cycle.
  assign rdy_g = !rst && state == BURST && !fifo_full;
  assign req_rdy = rdy_g ? NUM_REQ'(1) << grant_id : '0;
  assign acc = rdy_g && vld_g;
  assign fifo_wr_en = acc;
  assign done = acc && (last_g || beat_cnt == BW'(MAX_BURST - 1));
  assign grant_vld = state == BURST;
  always_comb begin
    state_nxt = state;
    id_nxt = grant_id;
    ptr_nxt = rr_ptr;
    cnt_nxt = beat_cnt;
    if (state == IDLE) begin
      if (any && !fifo_afull) begin
        state_nxt = BURST;
        id_nxt = win_idx;
        cnt_nxt = '0;
      end
    end else if (done || wdog_hit) begin
      state_nxt = IDLE;
      ptr_nxt = grant_id;
      cnt_nxt = '0;
    end else if (acc) begin
      cnt_nxt = beat_cnt + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      grant_id <= '0;
      beat_cnt <= '0;
      rr_ptr <= IW'(NUM_REQ - 1);
    end else begin
      state <= state_nxt;
      grant_id <= id_nxt;
      beat_cnt <= cnt_nxt;
      rr_ptr <= ptr_nxt;
    end
`ifdef FWA_WATCHDOG_EN
  logic [3:0] stall;
  assign wdog_hit = state == BURST && !vld_g && stall == 4'(WDOG_LIMIT);
  always_ff @(posedge clk)
    if (rst) begin
      stall <= '0;
      wdog_err <= 1'b0;
    end else begin
      wdog_err <= wdog_hit;
      stall <= (state == IDLE || acc || wdog_hit) ? '0 : (!vld_g ? stall + 1'b1 : stall);
    end
`else
  assign wdog_hit = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed and randomized checks of fifo_wr_arbiter against a cycle reference model.
module tb_fifo_wr_arbiter;
  localparam int N = 4, DW = 4, MB = 8;
  logic clk = 1'b0, rst = 1'b1, fifo_full = 1'b0, fifo_afull = 1'b0;
  logic [N-1:0] req_vld, req_last, req_rdy;
  logic [N*DW-1:0] req_data;
  logic fifo_wr_en, grant_vld;
  logic [DW-1:0] fifo_wr_data;
  logic [1:0] grant_id;
`ifdef FWA_WATCHDOG_EN
  logic wdog_err;
`endif
  int total = 0, bad = 0;
  int pkt_left[N];
  logic [DW-1:0] word[N];
  bit hold[N];
  bit m_busy = 0;
  int m_g = 0, m_gid = 0, m_beats = 0, m_ptr = N - 1;
  int cur_beats = 0, words_in = 0, words_out = 0;
  bit prev_gv = 0;
  int blen[$], gids[$];
  int exp_g[5] = '{0, 2, 3, 2, 2};
  int exp_b[5] = '{2, 8, 2, 8, 4};
  always #5 clk = ~clk;
  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk),
    .rst(rst),
    .req_vld(req_vld),
    .req_data(req_data),
    .req_last(req_last),
    .req_rdy(req_rdy),
    .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data),
    .fifo_full(fifo_full),
    .fifo_afull(fifo_afull),
`ifdef FWA_WATCHDOG_EN
    .wdog_err(wdog_err),
`endif
    .grant_vld(grant_vld),
    .grant_id(grant_id)
  );
  always_comb
    for (int i = 0; i < N; i++) begin
      req_vld[i] = pkt_left[i] > 0 && !hold[i];
      req_last[i] = pkt_left[i] == 1;
      req_data[i*DW +: DW] = word[i];
    end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic load(input int i, input int len);
    pkt_left[i] = len;
    words_in += len;
  endtask
  function automatic bit prod_busy();
    for (int i = 0; i < N; i++)
      if (pkt_left[i] > 0) return 1;
    return 0;
  endfunction
  task automatic clear_log();
    blen.delete();
    gids.delete();
    cur_beats = 0;
  endtask
  // One clock: check outputs at negedge against the model, then advance model and producers.
  task automatic cycle();
    logic [N-1:0] er, hs;
    bit acc, found;
    int nx;
    @(negedge clk);
    er = (m_busy && !rst && !fifo_full) ? N'(1) << m_g : '0;
    acc = er[m_g] && req_vld[m_g];
    chk("req_rdy", req_rdy, er);
    chk("wr_en", fifo_wr_en, acc);
    if (acc) chk("wr_data", fifo_wr_data, word[m_g]);
    chk("full_write", fifo_wr_en & fifo_full, 0);
    chk("grant_vld", grant_vld, m_busy);
    chk("grant_id", grant_id, m_gid);
    hs = req_vld & req_rdy;
    words_out += fifo_wr_en;
    if (grant_vld && fifo_wr_en) cur_beats++;
    if (prev_gv && !grant_vld) begin
      blen.push_back(cur_beats);
      gids.push_back(grant_id);
      cur_beats = 0;
    end
    prev_gv = grant_vld;
    @(posedge clk);
    #1;
    if (rst) begin
      m_busy = 0;
      m_gid = 0;
      m_beats = 0;
      m_ptr = N - 1;
    end else if (!m_busy) begin
      found = 0;
      nx = 0;
      for (int k = 1; k <= N; k++)
        if (!found && req_vld[(m_ptr + k) % N]) begin
          found = 1;
          nx = (m_ptr + k) % N;
        end
      if (found && !fifo_afull) begin
        m_busy = 1;
        m_g = nx;
        m_gid = nx;
        m_beats = 0;
      end
    end else if (acc) begin
      m_beats++;
      if (req_last[m_g] || m_beats == MB) begin
        m_busy = 0;
        m_ptr = m_g;
      end
    end
    for (int i = 0; i < N; i++)
      if (hs[i]) begin
        pkt_left[i]--;
        word[i] = DW'($urandom);
      end
  endtask
  task automatic drain(input int budget);
    int c = 0;
    while (c < budget && (prod_busy() || grant_vld)) begin
      cycle();
      c++;
    end
    cycle();
    chk("drain", (prod_busy() || grant_vld) ? 1 : 0, 0);
  endtask
  task automatic wait_grant();
    for (int c = 0; c < 20 && !grant_vld; c++) cycle();
  endtask
  initial begin
    for (int i = 0; i < N; i++) word[i] = DW'($urandom);
    @(posedge clk);
    #1;
    // Reset with every requester pending.
    for (int i = 0; i < N; i++) load(i, 2);
    repeat (2) cycle();
    rst = 1'b0;
    clear_log();
    drain(100);
    chk("rr_count", gids.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk("rr_order", gids[k], k);
      chk("rr_len", blen[k], 2);
    end
    // Long stream on requester 2 is cut into MAX_BURST pieces.
    clear_log();
    load(2, 20);
    load(3, 2);
    load(0, 2);
    drain(200);
    chk("cap_count", gids.size(), 5);
    for (int k = 0; k < 5; k++) begin
      chk("cap_gid", gids[k], exp_g[k]);
      chk("cap_len", blen[k], exp_b[k]);
    end
    // Full stalls a burst without losing or repeating words.
    clear_log();
    load(1, 6);
    wait_grant();
    chk("bp_gid", grant_id, 1);
    repeat (2) cycle();
    fifo_full = 1'b1;
    repeat (3) cycle();
    fifo_full = 1'b0;
    drain(50);
    chk("bp_bursts", blen.size(), 1);
    chk("bp_len", blen[0], 6);
    fifo_afull = 1'b1;
    load(3, 2);
    repeat (4) cycle();
    chk("afull_hold", grant_vld, 0);
    fifo_afull = 1'b0;
    drain(50);
    chk("afull_gid", grant_id, 3);
    // Lock while the owner pauses, then full coinciding with last.
    load(1, 4);
    wait_grant();
    cycle();
    hold[1] = 1;
    load(0, 2);
    load(2, 2);
    repeat (5) cycle();
    chk("lock_gid", grant_id, 1);
    chk("lock_vld", grant_vld, 1);
    hold[1] = 0;
    for (int c = 0; c < 10 && pkt_left[1] != 1; c++) cycle();
    fifo_full = 1'b1;
    repeat (2) cycle();
    chk("last_full_vld", grant_vld, 1);
    chk("last_full_left", pkt_left[1], 1);
    fifo_full = 1'b0;
    drain(100);
    // Random traffic with flags, pauses and occasional reset.
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        if (pkt_left[i] == 0 && $urandom_range(7) == 0) load(i, $urandom_range(12, 1));
        hold[i] = $urandom_range(4) == 0;
      end
      fifo_full = $urandom_range(7) == 0;
      fifo_afull = $urandom_range(3) == 0;
      rst = $urandom_range(149) == 0;
      cycle();
    end
    for (int i = 0; i < N; i++) hold[i] = 0;
    fifo_full = 1'b0;
    fifo_afull = 1'b0;
    rst = 1'b0;
    drain(600);
    chk("words", words_out, words_in);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
